// File: rtl/uart_rx_fifo_if.sv
// rtl/uart_rx_fifo_if.sv - receive FIFO write/pop/status bundle between uart_rx, the FIFO and its consumer.
// Optional RX_FIFO_OVERRUN_EN adds overrun/clr_overrun.
interface uart_rx_fifo_if #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
);
   logic              wr;
   logic [DATA_W-1:0] w_data;
   logic              rd_uart;
   logic [DATA_W-1:0] r_data;
   logic              rx_empty;
   logic              rx_full;
   logic [ADDR_W:0]   count;
`ifdef RX_FIFO_OVERRUN_EN
   logic              overrun;
   logic              clr_overrun;

   modport master (
      output wr, w_data, rd_uart, clr_overrun,
      input  r_data, rx_empty, rx_full, count, overrun
   );
   modport slave (
      input  wr, w_data, rd_uart, clr_overrun,
      output r_data, rx_empty, rx_full, count, overrun
   );
`else
   modport master (
      output wr, w_data, rd_uart,
      input  r_data, rx_empty, rx_full, count
   );
   modport slave (
      input  wr, w_data, rd_uart,
      output r_data, rx_empty, rx_full, count
   );
`endif
endinterface

// File: rtl/uart_rx_fifo.sv
// rtl/uart_rx_fifo.sv - show-ahead receive byte FIFO with registered empty/full/count.
// Optional RX_FIFO_OVERRUN_EN adds a sticky overrun flag for dropped bytes.
module uart_rx_fifo #(
   parameter int DATA_W = 8,
   parameter int ADDR_W = 4
) (
   input  logic              clock,
   input  logic              reset,
   uart_rx_fifo_if.slave     bus
);
   localparam int DEPTH = 2 ** ADDR_W;
   localparam logic [ADDR_W-1:0] PTR_ONE = ADDR_W'(1);
   localparam logic [ADDR_W:0]   CNT_ONE = (ADDR_W + 1)'(1);
   localparam logic [ADDR_W:0]   CNT_MAX_M1 = (ADDR_W + 1)'(DEPTH - 1);

   logic [DATA_W-1:0] mem_q [DEPTH];
   logic [ADDR_W-1:0] w_ptr_q, w_ptr_d;
   logic [ADDR_W-1:0] r_ptr_q, r_ptr_d;
   logic [ADDR_W:0]   count_q, count_d;
   logic              empty_q, empty_d;
   logic              full_q, full_d;
   logic              wr_en, rd_en;

   // A write at full is still accepted when a pop frees a slot on the same edge.
   assign rd_en = bus.rd_uart && !empty_q;
   assign wr_en = bus.wr && (!full_q || bus.rd_uart);

   always_comb begin
      w_ptr_d = w_ptr_q;
      r_ptr_d = r_ptr_q;
      count_d = count_q;
      empty_d = empty_q;
      full_d  = full_q;
      if (wr_en) w_ptr_d = w_ptr_q + PTR_ONE;
      if (rd_en) r_ptr_d = r_ptr_q + PTR_ONE;
      if (wr_en && !rd_en) begin
         count_d = count_q + CNT_ONE;
         empty_d = 1'b0;
         full_d  = (count_q == CNT_MAX_M1);
      end else if (rd_en && !wr_en) begin
         count_d = count_q - CNT_ONE;
         full_d  = 1'b0;
         empty_d = (count_q == CNT_ONE);
      end
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) begin
         w_ptr_q <= '0;
         r_ptr_q <= '0;
         count_q <= '0;
         empty_q <= 1'b1;
         full_q  <= 1'b0;
      end else begin
         w_ptr_q <= w_ptr_d;
         r_ptr_q <= r_ptr_d;
         count_q <= count_d;
         empty_q <= empty_d;
         full_q  <= full_d;
      end
   end

   // Storage is deliberately left out of reset.
   always_ff @(posedge clock) begin
      if (wr_en) mem_q[w_ptr_q] <= bus.w_data;
   end

   assign bus.r_data   = mem_q[r_ptr_q];
   assign bus.rx_empty = empty_q;
   assign bus.rx_full  = full_q;
   assign bus.count    = count_q;

`ifdef RX_FIFO_OVERRUN_EN
   logic overrun_q, overrun_d;

   always_comb begin
      overrun_d = overrun_q;
      if (bus.clr_overrun) overrun_d = 1'b0;
      if (bus.wr && full_q && !bus.rd_uart) overrun_d = 1'b1;
   end

   always_ff @(posedge clock or posedge reset) begin
      if (reset) overrun_q <= 1'b0;
      else       overrun_q <= overrun_d;
   end

   assign bus.overrun = overrun_q;
`endif
endmodule

// File: tb/tb_uart_rx_fifo.sv
// tb/tb_uart_rx_fifo.sv - directed and randomized checks of uart_rx_fifo against a queue model.
// Honours RX_FIFO_OVERRUN_EN when defined.
module tb_uart_rx_fifo;
   logic clock = 1'b0;
   logic reset = 1'b1;
   int   checks = 0;
   int   errors = 0;

   byte unsigned model_q[$];
   bit           model_ovr = 1'b0;

   uart_rx_fifo_if #(.DATA_W(8), .ADDR_W(4)) bus ();

   uart_rx_fifo #(.DATA_W(8), .ADDR_W(4)) dut (
      .clock (clock),
      .reset (reset),
      .bus   (bus)
   );

   always #5 clock = ~clock;

   task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         errors++;
         $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   task automatic check_state(input string tag);
      check({tag, ".empty"}, 32'(bus.rx_empty), 32'(model_q.size() == 0));
      check({tag, ".full"},  32'(bus.rx_full),  32'(model_q.size() == 16));
      check({tag, ".count"}, 32'(bus.count),    32'(model_q.size()));
      if (model_q.size() != 0)
         check({tag, ".r_data"}, 32'(bus.r_data), 32'(model_q[0]));
`ifdef RX_FIFO_OVERRUN_EN
      check({tag, ".overrun"}, 32'(bus.overrun), 32'(model_ovr));
`endif
   endtask

   // One clock: present inputs, take the edge, apply FIFO rules to the model.
   task automatic step(input bit w, input byte unsigned d, input bit r, input bit clr);
      int n;
      bit do_rd, do_wr;
      bus.wr      = w;
      bus.w_data  = d;
      bus.rd_uart = r;
`ifdef RX_FIFO_OVERRUN_EN
      bus.clr_overrun = clr;
`endif
      @(posedge clock);
      n     = model_q.size();
      do_rd = r && (n > 0);
      do_wr = w && ((n < 16) || r);
      if (w && (n == 16) && !r) model_ovr = 1'b1;
      else if (clr)             model_ovr = 1'b0;
      if (do_rd) void'(model_q.pop_front());
      if (do_wr) model_q.push_back(d);
      #1;
      bus.wr      = 1'b0;
      bus.rd_uart = 1'b0;
`ifdef RX_FIFO_OVERRUN_EN
      bus.clr_overrun = 1'b0;
`endif
   endtask

   initial begin
      bus.wr      = 1'b0;
      bus.w_data  = 8'h00;
      bus.rd_uart = 1'b0;
`ifdef RX_FIFO_OVERRUN_EN
      bus.clr_overrun = 1'b0;
`endif
      repeat (2) @(posedge clock);
      #1;
      check_state("reset_held");
      @(negedge clock);
      reset = 1'b0;
      #1;
      check_state("after_reset");

      for (int i = 0; i < 3; i++) begin
         step(1'b0, 8'h00, 1'b1, 1'b0);
         check_state("rd_on_empty");
      end

      step(1'b1, 8'h41, 1'b0, 1'b0);
      check_state("single_wr");
      check("single_wr.byte", 32'(bus.r_data), 32'h41);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_state("single_rd");

      for (int i = 0; i < 16; i++) begin
         step(1'b1, 8'(i), 1'b0, 1'b0);
         check_state("fill");
      end
      check("fill.full_const", 32'(bus.rx_full), 32'd1);
      check("fill.count_const", 32'(bus.count), 32'd16);
      step(1'b1, 8'hAA, 1'b0, 1'b0);
      check_state("drop_17th");
`ifdef RX_FIFO_OVERRUN_EN
      check("drop_17th.ovr_const", 32'(bus.overrun), 32'd1);
      step(1'b0, 8'h00, 1'b0, 1'b1);
      check_state("clr_overrun");
`endif
      for (int i = 0; i < 16; i++) begin
         check("drain.order", 32'(bus.r_data), 32'(i));
         step(1'b0, 8'h00, 1'b1, 1'b0);
         check_state("drain");
      end
      check("drain.empty_const", 32'(bus.rx_empty), 32'd1);

      step(1'b1, 8'h55, 1'b1, 1'b0);
      check_state("simul_empty");
      check("simul_empty.byte", 32'(bus.r_data), 32'h55);
      check("simul_empty.count", 32'(bus.count), 32'd1);
      step(1'b0, 8'h00, 1'b1, 1'b0);
      check_state("simul_empty_pop");

      for (int i = 0; i < 16; i++) step(1'b1, 8'(i), 1'b0, 1'b0);
      check_state("refill");
      step(1'b1, 8'h99, 1'b1, 1'b0);
      check_state("simul_full");
      check("simul_full.full", 32'(bus.rx_full), 32'd1);
      check("simul_full.head", 32'(bus.r_data), 32'h01);
      for (int i = 0; i < 16; i++) begin
         if (i == 15) check("simul_full.last", 32'(bus.r_data), 32'h99);
         step(1'b0, 8'h00, 1'b1, 1'b0);
         check_state("simul_full_drain");
      end

      for (int i = 0; i < 5; i++) step(1'b1, 8'(8'hC0 + i), 1'b0, 1'b0);
      check("pre_async.count", 32'(bus.count), 32'd5);
      #2;
      reset = 1'b1;
      #1;
      model_q.delete();
      model_ovr = 1'b0;
      check_state("async_reset");
      check("async_reset.count", 32'(bus.count), 32'd0);
      @(negedge clock);
      reset = 1'b0;
      step(1'b1, 8'h3C, 1'b0, 1'b0);
      check_state("post_reset_wr");
      check("post_reset_wr.byte", 32'(bus.r_data), 32'h3C);

      for (int phase = 0; phase < 3; phase++) begin
         int pw;
         pw = (phase == 0) ? 80 : (phase == 1) ? 50 : 20;
         for (int c = 0; c < 150; c++) begin
            bit w, r, clr;
            w   = ($urandom_range(0, 99) < pw);
            r   = ($urandom_range(0, 99) < (100 - pw));
            clr = ($urandom_range(0, 99) < 10);
            step(w, 8'($urandom), r, clr);
            check_state("random");
         end
      end

      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end
endmodule

// File: doc/uart_rx_fifo.md
Name: uart_rx_fifo

Overview:
Receive-side buffer between the UART receiver (uart_rx) and the loopback/consumer stage. Captures each byte on the receiver's done-tick pulse. Presents the oldest byte show-ahead on r_data, with empty/full status. The consumer pops the byte with a one-cycle rd_uart pulse.

Parameters:
DATA_W, 8, width of each stored word (UART byte)
ADDR_W, 4, address bits; depth = 2**ADDR_W = 16 entries

Ports:
clock  input  1  system clock; all state updates on posedge
reset  input  1  asynchronous, active-high reset
wr  input  1  write strobe; one-cycle pulse from the receiver's rx_done_tick
w_data  input  DATA_W  byte from the receiver; sampled when wr=1
rd_uart  input  1  pop strobe from the consumer; one pop per cycle it is high
r_data  output  DATA_W  oldest stored byte (show-ahead); valid while rx_empty=0
rx_empty  output  1  1 when FIFO holds 0 entries
rx_full  output  1  1 when FIFO holds 2**ADDR_W entries
count  output  ADDR_W+1  current occupancy, 0..2**ADDR_W

Behaviour:
- Storage: 2**ADDR_W x DATA_W register array; write pointer w_ptr and read pointer r_ptr, both ADDR_W bits; both wrap naturally from 2**ADDR_W-1 to 0.
- Reset (asynchronous, any time, including mid-transfer): w_ptr=0, r_ptr=0, count=0, rx_empty=1, rx_full=0. Array contents are not cleared. r_data is don't-care while rx_empty=1.
- r_data = mem[r_ptr] combinationally (first-word-fall-through):
  - A byte written at edge N appears on r_data, with rx_empty=0, after edge N. Write-to-visible latency is 1 cycle.
  - A consumer sampling r_data in the cycle it asserts rd_uart gets that byte.
- Write: on posedge with wr=1 and rx_full=0, mem[w_ptr]<=w_data and w_ptr increments.
- Read: on posedge with rd_uart=1 and rx_empty=0, r_ptr increments.
- Boundary rules:
  - wr=1 while rx_full=1 and rd_uart=0: byte dropped; pointers and flags unchanged.
  - rd_uart=1 while rx_empty=1: ignored; no pointer change, no underflow. The consumer may hold rd_uart high across empty cycles.
  - wr=1, rd_uart=1, rx_empty=1: write only. Next cycle count=1, rx_empty=0.
  - wr=1, rd_uart=1, rx_full=1: both occur. The new byte goes to the slot freed this cycle. rx_full stays 1; count unchanged.
  - wr=1, rd_uart=1, otherwise: both occur; count and flags unchanged.
- Flags: registered, updated on the same edge as the pointers.
  - rx_empty<=1 when a lone read leaves count 0.
  - rx_full<=1 when a lone write leaves count 2**ADDR_W.
  - rx_empty and rx_full are never both 1.
- count: registered. +1 on accepted lone write, -1 on accepted lone read, unchanged otherwise.
- No state machine beyond the pointer/flag pair. No combinational path from wr to rx_empty; rd_uart→r_data is a mux path only.

Optional Feature:
Macro RX_FIFO_OVERRUN_EN.
- Defined: adds ports overrun (output, 1) and clr_overrun (input, 1).
  - overrun sets to 1 on any posedge where wr=1, rx_full=1 and rd_uart=0 (byte dropped).
  - It stays set until clr_overrun=1 at a posedge. Set takes priority when set and clear coincide.
  - Reset clears it to 0.
- Undefined: ports absent, drop is silent, no extra logic.

Test Plan:
- Reset then idle: after reset, rx_empty=1, rx_full=0, count=0. rd_uart=1 for 3 cycles → pointers unchanged, count stays 0.
- Single byte: wr pulse with w_data=0x41 → next cycle rx_empty=0, count=1, r_data=0x41. rd_uart pulse → next cycle rx_empty=1, count=0.
- Fill/order: write 0x00..0x0F on 16 consecutive cycles → rx_full=1, count=16. A 17th write of 0xAA is dropped (overrun=1 if RX_FIFO_OVERRUN_EN). Reading 16 times yields 0x00..0x0F in order, then rx_empty=1.
- Simultaneous at empty: wr=1 w_data=0x55 with rd_uart=1 on the same edge → count=1, r_data=0x55.
- Simultaneous at full: full FIFO with head 0x00; wr=1 w_data=0x99 with rd_uart=1 → rx_full stays 1, count=16. The head advances to 0x01, and 0x99 is read out last.
- Async reset mid-stream: with count=5, assert reset between clock edges → rx_empty=1, count=0 immediately without waiting for an edge. Writes resume normally after deassertion.
